// File: rtl/rca_pipe_addsub.sv
// ---------------------------------------------------------------------------
// rca_pipe_addsub
//   Pipelined ripple-carry adder/subtractor with valid/ready flow control.
//   The operand is split into STAGES slices of W = DATA_WIDTH/STAGES bits.
//   Stage k ripples slice k. Untouched operand slices and finished result
//   slices travel alongside each beat in skew registers. The last stage is
//   the output register, so a beat appears STAGES cycles after it is
//   accepted. The whole pipe advances together and holds together, so
//   backpressure never drops or duplicates a beat.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      synchronous reset, active-low
//     in_valid   operand beat valid
//     in_ready   block accepts a beat this cycle (= !out_valid | out_ready)
//     A, B       operands, DATA_WIDTH bits
//     CIN        carry-in (add) / borrow-in (sub)
//     SUB        0: A+B+CIN, 1: A-B-CIN
//     out_valid  result valid
//     out_ready  consumer accepts result
//     SUM        result modulo 2^DATA_WIDTH
//     COUT       carry-out (add) / borrow-out (sub)
//     OVF        signed two's-complement overflow
//     ZERO       SUM == 0
//
//   DATA_WIDTH must be a multiple of STAGES, and 1 <= STAGES <= DATA_WIDTH.
// ---------------------------------------------------------------------------
module rca_pipe_addsub #(
    parameter int DATA_WIDTH = 8,
    parameter int STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  CIN,
    input  logic                  SUB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] SUM,
    output logic                  COUT,
    output logic                  OVF,
    output logic                  ZERO
);

    localparam int W    = DATA_WIDTH / STAGES;
    localparam int MSB  = DATA_WIDTH - 1;
    localparam int LAST = STAGES - 1;
    // Intermediate ranks between stages; STAGES=1 has none. A single rank is
    // kept in that case so that the arrays stay legal. That rank is never
    // read by a stage.
    localparam int PD   = (STAGES > 1) ? STAGES - 1 : 1;

    // Bit-level ripple over one slice: returns {carry_out, sum}.
    function automatic logic [W:0] rca_slice(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic         cin);
        logic [W-1:0] s;
        logic         c;
        s = '0;
        c = cin;
        for (int i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    logic adv;

    // Operands entering each stage: stage 0 takes the ports, stage k>0
    // takes the rank written by stage k-1.
    logic [DATA_WIDTH-1:0] stg_a     [STAGES];
    logic [DATA_WIDTH-1:0] stg_bx    [STAGES];
    logic [DATA_WIDTH-1:0] stg_sum   [STAGES];
    logic                  stg_c     [STAGES];
    logic                  stg_sub   [STAGES];
    logic                  stg_valid [STAGES];

    // Stage results.
    logic [W:0]            slice_res [STAGES];
    logic [DATA_WIDTH-1:0] nxt_sum   [STAGES];
    logic                  nxt_c     [STAGES];

    // Intermediate skew/pipeline ranks.
    logic [DATA_WIDTH-1:0] pipe_a_d     [PD];
    logic [DATA_WIDTH-1:0] pipe_a_q     [PD];
    logic [DATA_WIDTH-1:0] pipe_bx_d    [PD];
    logic [DATA_WIDTH-1:0] pipe_bx_q    [PD];
    logic [DATA_WIDTH-1:0] pipe_sum_d   [PD];
    logic [DATA_WIDTH-1:0] pipe_sum_q   [PD];
    logic                  pipe_c_d     [PD];
    logic                  pipe_c_q     [PD];
    logic                  pipe_sub_d   [PD];
    logic                  pipe_sub_q   [PD];
    logic                  pipe_valid_d [PD];
    logic                  pipe_valid_q [PD];

    // Output register (the last stage).
    logic                  out_valid_d, out_valid_q;
    logic [DATA_WIDTH-1:0] sum_d, sum_q;
    logic                  cout_d, cout_q;
    logic                  ovf_d, ovf_q;
    logic                  zero_d, zero_q;
    logic                  load_out;

    always_comb begin
        adv = !out_valid_q | out_ready;

        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                // Subtraction as A + ~B + ~CIN; the borrow-in becomes an inverted carry.
                stg_a[k]     = A;
                stg_bx[k]    = SUB ? ~B : B;
                stg_sum[k]   = '0;
                stg_c[k]     = SUB ? ~CIN : CIN;
                stg_sub[k]   = SUB;
                stg_valid[k] = in_valid;
            end else begin
                stg_a[k]     = pipe_a_q[k-1];
                stg_bx[k]    = pipe_bx_q[k-1];
                stg_sum[k]   = pipe_sum_q[k-1];
                stg_c[k]     = pipe_c_q[k-1];
                stg_sub[k]   = pipe_sub_q[k-1];
                stg_valid[k] = pipe_valid_q[k-1];
            end
            slice_res[k]          = rca_slice(stg_a[k][k*W +: W], stg_bx[k][k*W +: W], stg_c[k]);
            nxt_sum[k]            = stg_sum[k];
            nxt_sum[k][k*W +: W]  = slice_res[k][W-1:0];
            nxt_c[k]              = slice_res[k][W];
        end

        for (int j = 0; j < PD; j++) begin
            pipe_a_d[j]     = adv ? stg_a[j]     : pipe_a_q[j];
            pipe_bx_d[j]    = adv ? stg_bx[j]    : pipe_bx_q[j];
            pipe_sum_d[j]   = adv ? nxt_sum[j]   : pipe_sum_q[j];
            pipe_c_d[j]     = adv ? nxt_c[j]     : pipe_c_q[j];
            pipe_sub_d[j]   = adv ? stg_sub[j]   : pipe_sub_q[j];
            pipe_valid_d[j] = adv ? stg_valid[j] : pipe_valid_q[j];
        end

        // Result fields load only when a real beat arrives. A bubble
        // leaves the previous values in place.
        load_out    = adv & stg_valid[LAST];
        out_valid_d = adv ? stg_valid[LAST] : out_valid_q;
        sum_d       = load_out ? nxt_sum[LAST] : sum_q;
        cout_d      = load_out ? (stg_sub[LAST] ? ~nxt_c[LAST] : nxt_c[LAST]) : cout_q;
        ovf_d       = load_out ? ((stg_a[LAST][MSB] == stg_bx[LAST][MSB]) &
                                  (nxt_sum[LAST][MSB] != stg_a[LAST][MSB])) : ovf_q;
        zero_d      = load_out ? (nxt_sum[LAST] == '0) : zero_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < PD; j++) begin
                pipe_a_q[j]     <= '0;
                pipe_bx_q[j]    <= '0;
                pipe_sum_q[j]   <= '0;
                pipe_c_q[j]     <= 1'b0;
                pipe_sub_q[j]   <= 1'b0;
                pipe_valid_q[j] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            for (int j = 0; j < PD; j++) begin
                pipe_a_q[j]     <= pipe_a_d[j];
                pipe_bx_q[j]    <= pipe_bx_d[j];
                pipe_sum_q[j]   <= pipe_sum_d[j];
                pipe_c_q[j]     <= pipe_c_d[j];
                pipe_sub_q[j]   <= pipe_sub_d[j];
                pipe_valid_q[j] <= pipe_valid_d[j];
            end
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign SUM       = sum_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// ---------------------------------------------------------------------------
// tb_rca_pipe_addsub
//   Drives three configurations (8/2, 32/4, 16/1) from shared stimulus. Each
//   instance has its own monitor. The monitor keeps an arithmetic reference
//   result and the accept cycle of every beat in a queue, then checks the
//   results, their order and the latency as the beats leave.
// ---------------------------------------------------------------------------
module tb_rca_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_in, b_in;
    logic        cin_in, sub_in;

    logic        rdy8, ov8, co8, of8, z8;
    logic [7:0]  s8;
    logic        rdy32, ov32, co32, of32, z32;
    logic [31:0] s32;
    logic        rdy16, ov16, co16, of16, z16;
    logic [15:0] s16;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [35:0] exp_q [3][$];
    int          acc_q [3][$];
    int          stl_q [3][$];
    int          stall_cnt [3];
    int          out_cnt   [3];
    logic        rst_prev  [3];
    logic        hold      [3];
    logic [31:0] hold_sum  [3];

    always #5 clk = ~clk;

    rca_pipe_addsub #(.DATA_WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
        .A(a_in[7:0]), .B(b_in[7:0]), .CIN(cin_in), .SUB(sub_in),
        .out_valid(ov8), .out_ready(out_ready), .SUM(s8), .COUT(co8), .OVF(of8), .ZERO(z8));

    rca_pipe_addsub #(.DATA_WIDTH(32), .STAGES(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .A(a_in), .B(b_in), .CIN(cin_in), .SUB(sub_in),
        .out_valid(ov32), .out_ready(out_ready), .SUM(s32), .COUT(co32), .OVF(of32), .ZERO(z32));

    rca_pipe_addsub #(.DATA_WIDTH(16), .STAGES(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
        .A(a_in[15:0]), .B(b_in[15:0]), .CIN(cin_in), .SUB(sub_in),
        .out_valid(ov16), .out_ready(out_ready), .SUM(s16), .COUT(co16), .OVF(of16), .ZERO(z16));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference computed with plain integer arithmetic: {zero, ovf, cout, sum}.
    function automatic logic [35:0] ref_model(input int dw, input logic [31:0] a, input logic [31:0] b,
                                              input logic cin, input logic sub);
        longint mask, half, ua, ub, sa, sb, c, ru, rs;
        logic [31:0] s;
        logic co, ov;
        mask = (longint'(1) << dw) - 1;
        half = longint'(1) << (dw - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sb   = (ub >= half) ? ub - (mask + 1) : ub;
        c    = cin ? 1 : 0;
        if (sub) begin
            ru = ua - ub - c;
            co = (ru < 0);
            rs = sa - sb - c;
        end else begin
            ru = ua + ub + c;
            co = (ru > mask);
            rs = sa + sb + c;
        end
        s  = 32'(ru & mask);
        ov = (rs > half - 1) || (rs < -half);
        return {(s == 32'd0), ov, co, s};
    endfunction

    task automatic mon(input int id, input int dw, input int st, input logic rdy, input logic ov,
                       input logic [31:0] sum, input logic co, input logic of, input logic z);
        logic [35:0] e;
        int          acc, stl;
        if (rst_prev[id]) begin
            check_val($sformatf("d%0d_rst_valid", id), ov, 0);
            check_val($sformatf("d%0d_rst_sum", id), {sum, co, of, z}, 0);
            hold[id] = 1'b0;
        end
        if (hold[id]) begin
            check_val($sformatf("d%0d_hold_valid", id), ov, 1);
            check_val($sformatf("d%0d_hold_sum", id), sum, hold_sum[id]);
        end
        check_val($sformatf("d%0d_in_ready", id), rdy, !ov | out_ready);
        if (!rst_n) begin
            exp_q[id].delete();
            acc_q[id].delete();
            stl_q[id].delete();
            hold[id]     = 1'b0;
            rst_prev[id] = 1'b1;
            return;
        end
        rst_prev[id] = 1'b0;
        if (in_valid && rdy) begin
            exp_q[id].push_back(ref_model(dw, a_in, b_in, cin_in, sub_in));
            acc_q[id].push_back(cyc);
            stl_q[id].push_back(stall_cnt[id]);
        end
        if (ov && out_ready) begin
            check_val($sformatf("d%0d_pending", id), exp_q[id].size() > 0, 1);
            if (exp_q[id].size() > 0) begin
                e   = exp_q[id].pop_front();
                acc = acc_q[id].pop_front();
                stl = stl_q[id].pop_front();
                check_val($sformatf("d%0d_sum", id), sum, e[31:0]);
                check_val($sformatf("d%0d_cout", id), co, e[32]);
                check_val($sformatf("d%0d_ovf", id), of, e[33]);
                check_val($sformatf("d%0d_zero", id), z, e[34]);
                check_val($sformatf("d%0d_latency", id), cyc - acc, st + stall_cnt[id] - stl);
            end
            out_cnt[id]++;
        end
        if (ov && !out_ready) stall_cnt[id]++;
        hold[id]     = ov && !out_ready;
        hold_sum[id] = sum;
    endtask

    always @(negedge clk) begin
        mon(0, 8, 2, rdy8, ov8, {24'b0, s8}, co8, of8, z8);
        mon(1, 32, 4, rdy32, ov32, s32, co32, of32, z32);
        mon(2, 16, 1, rdy16, ov16, {16'b0, s16}, co16, of16, z16);
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
        a_in   = a;
        b_in   = b;
        cin_in = c;
        sub_in = s;
    endtask

    task automatic set_rand();
        a_in   = $urandom;
        b_in   = ($urandom_range(0, 7) == 0) ? a_in : $urandom;
        cin_in = 1'($urandom_range(0, 1));
        sub_in = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int snap, sent, k;
        logic acc;
        for (int i = 0; i < 3; i++) begin
            stall_cnt[i] = 0;
            out_cnt[i]   = 0;
            rst_prev[i]  = 1'b0;
            hold[i]      = 1'b0;
            hold_sum[i]  = '0;
        end
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_beat(0, 0, 0, 0);
        repeat (3) step();
        check_val("reset_out_valid", ov8, 0);
        check_val("reset_sum", s8, 0);
        check_val("reset_flags", {co8, of8, z8}, 0);
        check_val("reset_in_ready", rdy8, 1);
        rst_n = 1'b1;
        step();

        // Add with wraparound to zero.
        set_beat(32'hFF, 32'h01, 0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_val("t1_not_early", ov8, 0);
        check_val("t1_s1_valid", ov16, 1);
        check_val("t1_s1_sum", s16, 16'h0100);
        step();
        check_val("t1_valid", ov8, 1);
        check_val("t1_sum", s8, 8'h00);
        check_val("t1_cout", co8, 1);
        check_val("t1_ovf", of8, 0);
        check_val("t1_zero", z8, 1);

        // Subtract: signed overflow, then borrow.
        set_beat(32'h80, 32'h01, 0, 1);
        in_valid = 1'b1;
        step();
        set_beat(32'h05, 32'h07, 1, 1);
        step();
        in_valid = 1'b0;
        check_val("t2a_sum", s8, 8'h7F);
        check_val("t2a_cout", co8, 0);
        check_val("t2a_ovf", of8, 1);
        check_val("t2a_zero", z8, 0);
        step();
        check_val("t2b_sum", s8, 8'hFD);
        check_val("t2b_cout", co8, 1);
        check_val("t2b_ovf", of8, 0);
        check_val("t2b_zero", z8, 0);
        repeat (4) step();

        // 16 back-to-back beats.
        snap = out_cnt[0];
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_rand();
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        check_val("t3_count", out_cnt[0] - snap, 16);

        // Backpressure mid-stream.
        snap = out_cnt[0];
        sent = 0;
        k    = 0;
        set_rand();
        while (sent < 6 && k < 40) begin
            in_valid  = 1'b1;
            out_ready = !(k >= 3 && k < 6);
            #1;
            acc = rdy8;
            if (!out_ready && ov8) check_val("t4_stall_in_ready", rdy8, 0);
            step();
            if (acc) begin
                sent++;
                set_rand();
            end
            k++;
        end
        check_val("t4_sent", sent, 6);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        check_val("t4_count", out_cnt[0] - snap, 6);

        // Reset while two beats are in flight.
        in_valid = 1'b1;
        set_rand();
        step();
        set_rand();
        step();
        snap  = out_cnt[0];
        rst_n = 1'b0;
        set_rand();
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check_val("t5_out_valid", ov8, 0);
        check_val("t5_sum", s8, 0);
        check_val("t5_in_ready", rdy8, 1);
        repeat (4) step();
        check_val("t5_no_emerge", out_cnt[0] - snap, 0);
        set_rand();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_val("t5_lat_early", ov8, 0);
        step();
        check_val("t5_lat_valid", ov8, 1);
        repeat (4) step();

        // Long random run with random backpressure on all configurations.
        for (int i = 0; i < 1800; i++) begin
            set_rand();
            in_valid  = ($urandom_range(0, 9) < 9);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        check_val("drain_d8", exp_q[0].size(), 0);
        check_val("drain_d32", exp_q[1].size(), 0);
        check_val("drain_d16", exp_q[2].size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
